// File: rtl/uart_txrx.sv
// uart_txrx: 8N1 UART transmitter and receiver sharing one clock and reset.
// Reset `rst` is asynchronous and active low. The serial line idles high.
// Optional feature: define UART_FRAME_ERR_EN to add the `frame_err` output,
// a one-cycle pulse on a received frame whose stop bit is low.
module uart_txrx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       start,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_ready
`ifdef UART_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t   tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_idx;
    logic [7:0]  tx_shift;

    rx_state_t   rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_shift;
    logic        rx_s1;
    logic        rx_s2;
    logic        rx_armed;

    // Transmit FSM: latch the byte on start, hold each bit for CLKS_PER_BIT cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (start) begin
                        tx_shift <= data_in;
                        tx       <= 1'b0;
                        tx_busy  <= 1'b1;
                        tx_cnt   <= '0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx       <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == 3'd7) begin
                            tx       <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_idx <= tx_idx + 3'd1;
                            tx     <= tx_shift[tx_idx + 3'd1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_busy  <= 1'b0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous serial input; resets to idle-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    // Receive FSM: mid-bit sampling, glitch rejection, stop-bit validation.
    // The detection cycle counts toward the half bit (counter starts at 1), so
    // samples land mid-bit and data_ready arrives 2 + 9.5 bit times after the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_armed   <= 1'b1;
            data       <= '0;
            data_ready <= 1'b0;
`ifdef UART_FRAME_ERR_EN
            frame_err  <= 1'b0;
`endif
        end else begin
            data_ready <= 1'b0;
`ifdef UART_FRAME_ERR_EN
            frame_err  <= 1'b0;
`endif
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (!rx_armed) begin
                        // After a framing error, wait for the line to return high.
                        if (rx_s2) rx_armed <= 1'b1;
                    end else if (!rx_s2) begin
                        rx_cnt   <= 16'd1;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        if (rx_s2) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_idx   <= '0;
                            rx_state <= RX_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_idx <= rx_idx + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s2) begin
                            data       <= rx_shift;
                            data_ready <= 1'b1;
                        end else begin
                            rx_armed  <= 1'b0;
`ifdef UART_FRAME_ERR_EN
                            frame_err <= 1'b1;
`endif
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_txrx.sv
// tb_uart_txrx: directed and randomized checks of uart_txrx (CLKS_PER_BIT=16),
// using loopback and a bit-banged serial driver. Honours UART_FRAME_ERR_EN.
module tb_uart_txrx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       start = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic       rx;
    logic [7:0] data;
    logic       data_ready;
`ifdef UART_FRAME_ERR_EN
    logic       frame_err;
`endif

    logic loopback = 1'b1;
    logic rx_drv   = 1'b1;
    assign rx = loopback ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_txrx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .start     (start),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .rx        (rx),
        .data      (data),
        .data_ready(data_ready)
`ifdef UART_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    int passed = 0;
    int total  = 0;

    // Free-running cycle count and receive-event monitors (single writers).
    int         cyc = 0;
    int         dr_cnt = 0;
    int         dr_cyc = 0;
    logic [7:0] dr_data = 8'h00;
    int         fe_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && data_ready) begin
            dr_cnt  <= dr_cnt + 1;
            dr_cyc  <= cyc;
            dr_data <= data;
        end
`ifdef UART_FRAME_ERR_EN
        if (rst && frame_err) fe_cnt <= fe_cnt + 1;
`endif
    end

    // Expected serial frame: bit 0 start (0), bits 1..8 data LSB first, bit 9 stop (1).
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic [9:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i + 1] = (b >> i) & 8'h01;
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] last_good = 8'h00;

    // Send one byte through tx (loopback), checking the line pattern, busy
    // duration, receive latency and data. Returns at the cycle tx_busy falls,
    // so a following call starts back-to-back.
    task automatic send(input logic [7:0] b, input bit poke);
        logic [9:0] got;
        int busy_n;
        int t0;
        int d0;
        got    = '0;
        busy_n = 0;
        d0     = dr_cnt;
        data_in = b;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        data_in = 8'($urandom);
        t0 = cyc;
        chk("busy_rise", 32'(tx_busy), 32'd1);
        for (int c = 0; c < 10 * CPB; c++) begin
            if (tx_busy) busy_n++;
            if (c % CPB == CPB / 2) got[c / CPB] = tx;
            if (poke) begin
                if (c >= 40 && c < 48) begin
                    start   = 1'b1;
                    data_in = 8'h3C;
                end else begin
                    start = 1'b0;
                end
            end
            tick();
        end
        start = 1'b0;
        chk("tx_frame", 32'(got), 32'(frame_of(b)));
        chk("busy_cycles", 32'(busy_n), 32'(10 * CPB));
        chk("busy_fall", 32'(tx_busy), 32'd0);
        chk("rx_pulses", 32'(dr_cnt - d0), 32'd1);
        chk("rx_byte", 32'(dr_data), 32'(b));
        chk("rx_data_hold", 32'(data), 32'(b));
        chk("rx_latency", 32'((dr_cyc - t0 >= 2 + 9 * CPB + CPB / 2 - 1) &&
                              (dr_cyc - t0 <= 2 + 9 * CPB + CPB / 2 + 1)), 32'd1);
        last_good = b;
    endtask

    // Bit-bang a frame onto rx with the chosen stop-bit level, then idle high.
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = frame_of(b);
        f[9] = stop_bit;
        for (int k = 0; k < 10; k++) begin
            rx_drv = f[k];
            repeat (CPB) tick();
        end
        rx_drv = 1'b1;
        repeat (2 * CPB) tick();
    endtask

    initial begin
        int d0;
        int f0;
        logic [7:0] b;

        // Reset state
        #2 rst = 1'b0;
        repeat (3) tick();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_ready", 32'(data_ready), 32'd0);
        rst = 1'b1;
        repeat (4) tick();

        // Directed loopback, back-to-back frames, start ignored while busy
        send(8'hD5, 1'b0);
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        repeat (3) tick();
        send(8'hA5, 1'b1);
        tick();
        chk("no_queued_frame", 32'({tx_busy, tx}), 32'b01);
        repeat (CPB * 11) tick();
        chk("no_extra_rx", 32'(data), 32'hA5);

        // Randomized loopback bytes
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom);
            send(b, 1'b0);
        end

        // Glitch on rx is rejected, then a valid frame is received
        loopback = 1'b0;
        rx_drv   = 1'b1;
        repeat (4) tick();
        d0 = dr_cnt;
        rx_drv = 1'b0;
        repeat (5) tick();
        rx_drv = 1'b1;
        repeat (3 * CPB) tick();
        chk("glitch_no_ready", 32'(dr_cnt - d0), 32'd0);
        chk("glitch_data_hold", 32'(data), 32'(last_good));
        b = 8'($urandom);
        d0 = dr_cnt;
        drive_frame(b, 1'b1);
        chk("after_glitch_pulses", 32'(dr_cnt - d0), 32'd1);
        chk("after_glitch_byte", 32'(data), 32'(b));
        last_good = b;

        // Bad stop bit: no data_ready, data unchanged
        d0 = dr_cnt;
        f0 = fe_cnt;
        drive_frame(~b, 1'b0);
        chk("ferr_no_ready", 32'(dr_cnt - d0), 32'd0);
        chk("ferr_data_hold", 32'(data), 32'(last_good));
`ifdef UART_FRAME_ERR_EN
        chk("ferr_pulse", 32'(fe_cnt - f0), 32'd1);
`endif
        b = 8'($urandom);
        d0 = dr_cnt;
        drive_frame(b, 1'b1);
        chk("after_ferr_pulses", 32'(dr_cnt - d0), 32'd1);
        chk("after_ferr_byte", 32'(data), 32'(b));
        last_good = b;

        // Reset mid-frame, then a fresh loopback frame
        loopback = 1'b1;
        repeat (4) tick();
        data_in = 8'h77;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (5 * CPB) tick();
        rst = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(tx_busy), 32'd0);
        chk("midrst_ready", 32'(data_ready), 32'd0);
        chk("midrst_data", 32'(data), 32'h00);
        repeat (3) tick();
        rst = 1'b1;
        d0 = dr_cnt;
        repeat (12 * CPB) tick();
        chk("midrst_abandon", 32'(dr_cnt - d0), 32'd0);
        chk("midrst_idle", 32'({tx_busy, tx}), 32'b01);
        send(8'h5A, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
